// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter: loads a DW-bit word on start&ready, drains it on sdo
// one bit per enabled cycle, optional even-parity bit (PISO_PARITY_EN), then pulses done.
// Ports: clk, rst (sync, active-low), enb, sync_clr, start, data[DW-1:0]
//        -> ready, busy, sdo, sdo_valid, done.
module piso_shifter #(
  parameter int DW        = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          sync_clr,
  input  logic          start,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          busy,
  output logic          sdo,
  output logic          sdo_valid,
  output logic          done
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef PISO_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   shreg;
  logic [CW-1:0]   cnt;
`ifdef PISO_PARITY_EN
  logic            par;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else if (enb) begin
      state <= sync_clr ? S_IDLE : state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
`ifdef PISO_PARITY_EN
        if (cnt == LAST) state_nx = S_PARITY;
`else
        if (cnt == LAST) state_nx = S_DONE;
`endif
      end
`ifdef PISO_PARITY_EN
      S_PARITY: state_nx = S_DONE;
`endif
      S_DONE: begin
        // first DONE cycle raises done, second one retires the frame
        if (done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      cnt       <= '0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (enb) begin
      if (sync_clr) begin
        shreg     <= '0;
        cnt       <= '0;
        sdo       <= 1'b0;
        sdo_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
`ifdef PISO_PARITY_EN
        par       <= 1'b0;
`endif
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              shreg <= data;
              cnt   <= '0;
              busy  <= 1'b1;
`ifdef PISO_PARITY_EN
              par   <= ^data;
`endif
            end
          end
          S_SHIFT: begin
            sdo       <= LSB_FIRST ? shreg[0] : shreg[DW-1];
            sdo_valid <= 1'b1;
            shreg     <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            // saturate so the count never wraps inside a frame
            if (cnt != LAST) cnt <= cnt + CW'(1);
          end
`ifdef PISO_PARITY_EN
          S_PARITY: begin
            sdo       <= par;
            sdo_valid <= 1'b1;
          end
`endif
          S_DONE: begin
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            if (!done) begin
              done <= 1'b1;
            end else begin
              done <= 1'b0;
              busy <= 1'b0;
            end
          end
          default: begin
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
